// File: rtl/fifo_wr_wide_to_narrow_if.sv
// fifo_wr_wide_to_narrow_if: block-in / word-out handshake bundle for the wide-to-narrow serializer
interface fifo_wr_wide_to_narrow_if #(
  parameter int I_W = 128,
  parameter int O_W = 32,
  parameter int CW  = 3
);
  logic [I_W-1:0] idata;
  logic [CW-1:0]  i_nwords;
  logic           i_push;
  logic           rdy;
  logic           not_full;
  logic [O_W-1:0] odata;
  logic           o_push;
  logic           busy;
  logic           ovf;
  modport master (output idata, i_nwords, i_push, not_full, input rdy, odata, o_push, busy, ovf);
  modport slave  (input idata, i_nwords, i_push, not_full, output rdy, odata, o_push, busy, ovf);
endinterface

// File: rtl/fifo_wr_wide_to_narrow.sv
// fifo_wr_wide_to_narrow: serializes wide blocks into narrow FIFO pushes, with a one-block hold buffer
module fifo_wr_wide_to_narrow #(
  parameter int I_W       = 128,
  parameter int O_W       = 32,
  parameter int MSB_FIRST = 1,
  parameter int GAP_EN    = 1
) (
  input logic clk,
  input logic reset,
  fifo_wr_wide_to_narrow_if.slave bus
);
  localparam int RATIO = I_W / O_W;
  localparam int CW    = $clog2(RATIO) + 1;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  logic [0:0]     r_state;
  logic [I_W-1:0] r_sr, r_hb;
  logic [CW-1:0]  r_rem, r_hb_n;
  logic           r_hv;
  logic           w_acc, w_emit, w_sr_free, w_hb_wr, w_hv_nx;
  logic [0:0]     w_state_nx;
  logic [CW-1:0]  w_n;
  logic [O_W-1:0] w_head;
  logic [I_W-1:0] w_shifted;
  assign w_acc      = bus.i_push && bus.rdy;
  assign w_n        = (bus.i_nwords == '0 || bus.i_nwords > CW'(RATIO)) ? CW'(RATIO) : bus.i_nwords;
  assign w_emit     = r_state == S_SHIFT && bus.not_full && (GAP_EN == 0 || !bus.o_push);
  // SR is free when idle or when its last word leaves on this edge, so blocks chain without a bubble
  assign w_sr_free  = r_state == S_IDLE || (w_emit && r_rem == CW'(1));
  assign w_hb_wr    = w_acc && !(w_sr_free && !r_hv);
  assign w_hv_nx    = (r_hv && !w_sr_free) || w_hb_wr;
  assign w_state_nx = w_sr_free ? ((r_hv || w_acc) ? S_SHIFT : S_IDLE) : S_SHIFT;
  assign w_head     = (MSB_FIRST != 0) ? r_sr[I_W-1 -: O_W] : r_sr[O_W-1:0];
  assign w_shifted  = (MSB_FIRST != 0) ? r_sr << O_W : r_sr >> O_W;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_rem      <= '0;
      r_hb       <= '0;
      r_hb_n     <= '0;
      r_hv       <= 1'b0;
      bus.rdy    <= 1'b0;
      bus.odata  <= '0;
      bus.o_push <= 1'b0;
      bus.busy   <= 1'b0;
      bus.ovf    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_hv       <= w_hv_nx;
      bus.rdy    <= !w_hv_nx;
      bus.busy   <= (w_state_nx == S_SHIFT) || w_hv_nx;
      bus.o_push <= w_emit;
      bus.ovf    <= bus.ovf || (bus.i_push && !bus.rdy);
      if (w_emit) bus.odata <= w_head;
      if (w_sr_free && r_hv) begin
        r_sr  <= r_hb;
        r_rem <= r_hb_n;
      end else if (w_sr_free && w_acc) begin
        r_sr  <= bus.idata;
        r_rem <= w_n;
      end else if (w_emit) begin
        r_sr  <= w_shifted;
        r_rem <= r_rem - CW'(1);
      end
      if (w_hb_wr) begin
        r_hb   <= bus.idata;
        r_hb_n <= w_n;
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_wide_to_narrow.sv
// tb_fifo_wr_wide_to_narrow: three configurations driven in parallel, checked against a word-queue model
module tb_fifo_wr_wide_to_narrow;
  localparam int I_W = 128, O_W = 32, RATIO = 4, CW = 3;
  localparam logic [I_W-1:0] BLK = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic clk = 0, reset = 0;
  logic [I_W-1:0] idata = '0;
  logic [CW-1:0] nw = '0;
  logic ipush = 0, nf = 1;
  always #5 clk = ~clk;
  fifo_wr_wide_to_narrow_if #(.I_W(I_W), .O_W(O_W), .CW(CW)) b0(), b1(), b2();
  fifo_wr_wide_to_narrow #(.I_W(I_W), .O_W(O_W), .MSB_FIRST(1), .GAP_EN(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  fifo_wr_wide_to_narrow #(.I_W(I_W), .O_W(O_W), .MSB_FIRST(1), .GAP_EN(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  fifo_wr_wide_to_narrow #(.I_W(I_W), .O_W(O_W), .MSB_FIRST(0), .GAP_EN(0)) u2 (.clk(clk), .reset(reset), .bus(b2));
  assign {b0.idata, b0.i_nwords, b0.i_push, b0.not_full} = {idata, nw, ipush, nf};
  assign {b1.idata, b1.i_nwords, b1.i_push, b1.not_full} = {idata, nw, ipush, nf};
  assign {b2.idata, b2.i_nwords, b2.i_push, b2.not_full} = {idata, nw, ipush, nf};
  logic [2:0] rdy_v, push_v, busy_v, ovf_v;
  logic [O_W-1:0] od_v [3];
  assign rdy_v  = {b2.rdy, b1.rdy, b0.rdy};
  assign push_v = {b2.o_push, b1.o_push, b0.o_push};
  assign busy_v = {b2.busy, b1.busy, b0.busy};
  assign ovf_v  = {b2.ovf, b1.ovf, b0.ovf};
  assign od_v[0] = b0.odata;
  assign od_v[1] = b1.odata;
  assign od_v[2] = b2.odata;
  int nv = 0, ne = 0, cyc = 0;
  logic [O_W-1:0] wq [3][$];
  int bq [3][$];
  logic [2:0] m_push = '0, m_rdy = '0, m_busy = '0, m_ovf = '0;
  logic [O_W-1:0] m_data [3] = '{default: '0};
  function automatic bit gap(int k); return k == 1; endfunction
  function automatic bit msb(int k); return k != 2; endfunction
  function automatic int n_eff(logic [CW-1:0] n);
    return (n == '0 || int'(n) > RATIO) ? RATIO : int'(n);
  endfunction
  function automatic logic [O_W-1:0] word_of(logic [I_W-1:0] d, int i, bit m);
    return m ? O_W'(d >> (I_W - O_W * (i + 1))) : O_W'(d >> (O_W * i));
  endfunction
  function automatic logic [I_W-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // Advance one clock: compare every instance with the model, then apply the upcoming edge to the model.
  task automatic tick();
    bit emit;
    int n;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        wq[k].delete();
        bq[k].delete();
        {m_push[k], m_rdy[k], m_busy[k], m_ovf[k]} = '0;
        m_data[k] = '0;
      end
      nv++;
      if ({push_v[k], rdy_v[k], busy_v[k], ovf_v[k]} !== {m_push[k], m_rdy[k], m_busy[k], m_ovf[k]} || od_v[k] !== m_data[k]) begin
        ne++;
        $display("FAIL scoreboard inst %0d cyc %0d: push/rdy/busy/ovf=%b%b%b%b odata=%h, want %b%b%b%b %h",
                 k, cyc, push_v[k], rdy_v[k], busy_v[k], ovf_v[k], od_v[k], m_push[k], m_rdy[k], m_busy[k], m_ovf[k], m_data[k]);
      end
      if (!reset) begin
        emit = wq[k].size() > 0 && nf && !(gap(k) && m_push[k]);
        if (emit) begin
          m_data[k] = wq[k].pop_front();
          bq[k][0] = bq[k][0] - 1;
          if (bq[k][0] == 0) void'(bq[k].pop_front());
        end
        m_push[k] = emit;
        if (ipush && m_rdy[k]) begin
          n = n_eff(nw);
          for (int i = 0; i < n; i++) wq[k].push_back(word_of(idata, i, msb(k)));
          bq[k].push_back(n);
        end else if (ipush) m_ovf[k] = 1'b1;
        m_rdy[k]  = bq[k].size() < 2;
        m_busy[k] = bq[k].size() > 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic push_block(input logic [I_W-1:0] d, input logic [CW-1:0] n);
    idata = d;
    nw = n;
    ipush = 1;
    tick();
    ipush = 0;
  endtask
  task automatic test_reset();
    #2 reset = 1;
    tick();
    tick();
    nv++;
    if ({push_v, rdy_v, busy_v, ovf_v} !== '0 || od_v[0] !== '0 || od_v[1] !== '0 || od_v[2] !== '0) begin
      ne++;
      $display("FAIL reset_state: push=%b rdy=%b busy=%b ovf=%b, want all zero", push_v, rdy_v, busy_v, ovf_v);
    end
    reset = 0;
    tick();
    nv++;
    if (rdy_v !== 3'b111) begin ne++; $display("FAIL rdy_after_reset: rdy=%b, want 111", rdy_v); end
  endtask
  task automatic test_single();
    logic [O_W-1:0] e [4] = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    logic [O_W-1:0] got [3][4];
    logic [11:0] pm [3];
    logic [11:0] epm;
    int gi [3];
    for (int k = 0; k < 3; k++) begin pm[k] = '0; gi[k] = 0; end
    push_block(BLK, '0);
    for (int j = 1; j < 12; j++) begin
      tick();
      for (int k = 0; k < 3; k++) if (push_v[k]) begin
        pm[k][j] = 1'b1;
        if (gi[k] < 4) got[k][gi[k]] = od_v[k];
        gi[k]++;
      end
    end
    for (int k = 0; k < 3; k++) begin
      epm = gap(k) ? 12'h0AA : 12'h01E;
      nv++;
      if (pm[k] !== epm) begin ne++; $display("FAIL single_timing inst %0d: push cycles=%b, want %b", k, pm[k], epm); end
      for (int i = 0; i < 4; i++) begin
        nv++;
        if (got[k][i] !== (msb(k) ? e[i] : e[3-i])) begin
          ne++;
          $display("FAIL single_data inst %0d word %0d: got %h, want %h", k, i, got[k][i], msb(k) ? e[i] : e[3-i]);
        end
      end
    end
    nv++;
    if (busy_v !== 3'b000) begin ne++; $display("FAIL single_busy: busy=%b, want 000", busy_v); end
  endtask
  task automatic test_back_to_back();
    int cnt = 0, first = -1, last = -1;
    idata = rand_blk(); nw = '0; ipush = 1;
    tick();
    nv++;
    if (rdy_v !== 3'b111) begin ne++; $display("FAIL b2b_rdy_second: rdy=%b, want 111", rdy_v); end
    idata = rand_blk();
    tick();
    ipush = 0;
    for (int j = 0; j < 14; j++) begin
      if (j > 0) tick();
      if (push_v[0]) begin cnt++; if (first < 0) first = j; last = j; end
      if (j == 0 || j == 2) begin
        nv++;
        if (rdy_v[0] !== 1'b0) begin ne++; $display("FAIL b2b_rdy_low j=%0d: rdy=%b, want 0", j, rdy_v[0]); end
      end
      if (j == 3) begin
        nv++;
        if (rdy_v[0] !== 1'b1) begin ne++; $display("FAIL b2b_rdy_rise: rdy=%b, want 1", rdy_v[0]); end
      end
    end
    nv++;
    if (cnt != 8 || first != 0 || last != 7) begin
      ne++;
      $display("FAIL b2b_contig: %0d pushes from %0d to %0d, want 8 from 0 to 7", cnt, first, last);
    end
  endtask
  task automatic test_stall();
    logic [I_W-1:0] d = rand_blk();
    push_block(d, '0);
    tick();
    tick();
    nv++;
    if (push_v[0] !== 1'b1 || od_v[0] !== word_of(d, 1, 1)) begin
      ne++; $display("FAIL stall_word2: push=%b odata=%h, want 1 %h", push_v[0], od_v[0], word_of(d, 1, 1));
    end
    nf = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      nv++;
      if (push_v[0] !== 1'b0) begin ne++; $display("FAIL stall_quiet j=%0d: push=%b, want 0", j, push_v[0]); end
    end
    nf = 1;
    for (int i = 2; i < 4; i++) begin
      tick();
      nv++;
      if (push_v[0] !== 1'b1 || od_v[0] !== word_of(d, i, 1)) begin
        ne++; $display("FAIL stall_resume word %0d: push=%b odata=%h, want 1 %h", i, push_v[0], od_v[0], word_of(d, i, 1));
      end
    end
    repeat (10) tick();
  endtask
  task automatic test_partial_ovf();
    int cnt = 0;
    push_block(rand_blk(), 3'd2);
    for (int j = 0; j < 8; j++) begin tick(); if (push_v[0]) cnt++; end
    nv++;
    if (cnt != 2 || busy_v[0] !== 1'b0) begin ne++; $display("FAIL partial: %0d pushes busy=%b, want 2 0", cnt, busy_v[0]); end
    nv++;
    if (ovf_v !== 3'b000) begin ne++; $display("FAIL ovf_clear: ovf=%b, want 000", ovf_v); end
    cnt = 0;
    nw = '0;
    ipush = 1;
    for (int j = 0; j < 3; j++) begin idata = rand_blk(); tick(); if (push_v[0]) cnt++; end
    ipush = 0;
    nv++;
    if (ovf_v !== 3'b111) begin ne++; $display("FAIL ovf_set: ovf=%b, want 111", ovf_v); end
    for (int j = 0; j < 16; j++) begin tick(); if (push_v[0]) cnt++; end
    nv++;
    if (cnt != 8) begin ne++; $display("FAIL ovf_stream: %0d pushes, want 8", cnt); end
  endtask
  task automatic test_reset_mid();
    logic [I_W-1:0] d = rand_blk();
    push_block(d, '0);
    tick();
    nv++;
    if (push_v[0] !== 1'b1) begin ne++; $display("FAIL midrst_pre: push=%b, want 1", push_v[0]); end
    reset = 1;
    #1;
    nv++;
    if ({push_v, rdy_v, busy_v, ovf_v} !== '0 || od_v[0] !== '0 || od_v[1] !== '0 || od_v[2] !== '0) begin
      ne++; $display("FAIL midrst_clear: push=%b rdy=%b busy=%b ovf=%b od0=%h, want zero", push_v, rdy_v, busy_v, ovf_v, od_v[0]);
    end
    tick();
    tick();
    reset = 0;
    tick();
    d = rand_blk();
    push_block(d, '0);
    tick();
    nv++;
    if (push_v[0] !== 1'b1 || od_v[0] !== word_of(d, 0, 1) || od_v[2] !== word_of(d, 0, 0)) begin
      ne++; $display("FAIL midrst_next: push=%b od0=%h od2=%h, want 1 %h %h", push_v[0], od_v[0], od_v[2], word_of(d, 0, 1), word_of(d, 0, 0));
    end
    repeat (10) tick();
  endtask
  task automatic test_random();
    for (int j = 0; j < 400; j++) begin
      idata = rand_blk();
      nw = CW'($urandom_range(0, 7));
      ipush = $urandom_range(0, 2) == 0;
      nf = $urandom_range(0, 3) != 0;
      tick();
    end
    ipush = 0;
    nf = 1;
    repeat (40) tick();
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_partial_ovf();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nv, ne);
    $finish;
  end
endmodule

// File: doc/fifo_wr_wide_to_narrow.md
Name: fifo_wr_wide_to_narrow

Overview:
Parametrised wide-to-narrow write serializer feeding the 32-bit OPB write FIFO (or any narrow push-only FIFO) from the AES accelerator datapath.
- Accepts one I_W-bit block per i_push/rdy handshake and emits its narrow O_W-bit words as single-cycle o_push strobes, gated by not_full.
- Adds three features: a one-block holding buffer so the next block can be accepted while the current one drains, partial blocks via i_nwords, and selectable word order.
- Optional one-idle-cycle gap between pushes preserves compatibility with slow FIFOs.

Parameters:
- I_W, 128, input block width; must be an integer multiple of O_W.
- O_W, 32, output word width.
- RATIO, I_W/O_W, derived; words per block (must be >= 2).
- CW, clog2(RATIO)+1, width of i_nwords.
- MSB_FIRST, 1, 1 = emit idata[I_W-1 -: O_W] first; 0 = emit idata[O_W-1:0] first.
- GAP_EN, 1, 1 = never assert o_push on two consecutive cycles; 0 = back-to-back pushes allowed.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- idata  in  I_W  input block, sampled when i_push is high and rdy is high.
- i_nwords  in  CW  number of valid words in idata, counted from the first-emitted end; 0 or >RATIO means RATIO.
- i_push  in  1  block valid strobe.
- rdy  out  1  registered; high when a block can be accepted this cycle.
- not_full  in  1  downstream FIFO can take a word this cycle.
- odata  out  O_W  registered output word.
- o_push  out  1  registered single-word push strobe.
- busy  out  1  registered; high while any word is pending (shift register or hold buffer).
- ovf  out  1  sticky; set when i_push arrives while rdy is low; cleared only by reset.

Behaviour:
- Reset (asynchronous): rdy=0, odata=0, o_push=0, busy=0, ovf=0, hold_valid=0, state=IDLE, remaining count=0. The first clock edge after reset deasserts sets rdy=1.
- Storage: a shift register (SR) with a remaining-word count (rem), plus a hold buffer (HB) storing data, nwords and hold_valid.
- rdy_next = ~hold_valid_next. A block accepted while SR is empty goes directly into SR. A block accepted while SR is draining goes into HB.
- States:
  - IDLE: SR empty. On accept, load SR, go to SHIFT.
  - SHIFT: emission cycle when not_full=1 and (GAP_EN=0 or o_push=0). On an emission cycle, odata_next=current SR head word, o_push_next=1, shift SR by O_W toward the head, rem-=1.
  - When the last word (rem=1) is emitted: if HB is valid, load SR from HB in the same edge and clear hold_valid; else go to IDLE.
  - A new accept on the same edge as the HB-to-SR transfer writes HB.
- Non-emission cycles: o_push_next=0 and odata holds its value.
- Latency: with not_full=1 and GAP_EN=0, i_push accepted in cycle N produces o_push high in cycles N+2 .. N+1+nwords. With GAP_EN=1, pushes land on alternate cycles starting at N+2.
- Throughput: with GAP_EN=0, continuous blocks sustain one word per cycle with no bubble between blocks.
- not_full low: emission stalls with no loss. Words are never dropped, and are never emitted while not_full=0 in the decision cycle.
- i_push while rdy=0: data is ignored, ovf is set, and state is unchanged.
- busy = (state==SHIFT) | hold_valid, registered.
- Unknown state encoding: return to IDLE.

Test Plan:
- Reset, then one push of idata=0x00112233_44556677_8899AABB_CCDDEEFF, nwords=0, MSB_FIRST=1, GAP_EN=0, not_full=1 -> odata 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles starting N+2; busy falls afterward.
- Same block with GAP_EN=1 -> o_push at N+2, N+4, N+6, N+8 with the same data order. With MSB_FIRST=0 the order is 0xCCDDEEFF first.
- Two blocks pushed on consecutive rdy cycles, GAP_EN=0 -> 8 contiguous pushes; rdy drops after the second accept and rises again once the HB-to-SR transfer occurs.
- not_full deasserted for 5 cycles after the second word -> o_push stays low throughout the stall; words 3 and 4 follow unchanged once not_full returns.
- i_nwords=2 -> exactly 2 pushes (0x00112233, 0x44556677), then IDLE. A push with rdy=0 (HB full) -> ovf=1 and the output stream is unaffected.
- Reset asserted mid-block after 1 word -> outputs cleared immediately, no further o_push; the next block after reset emits from its first word.
